// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between the result FSM (master) and the BCD converter (slave).
// The neg signal exists only when SIGNED_IN_EN is defined.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;
`ifdef SIGNED_IN_EN
    logic                  neg;

    modport master (output start, bin_in, input busy, done, bcd_out, overflow, neg);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow, neg);
`else
    modport master (output start, bin_in, input busy, done, bcd_out, overflow);
    modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional macro SIGNED_IN_EN: two's complement input, magnitude converted, sign on neg.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int          SW       = 4 * DIGITS;
    localparam int          CW       = $clog2(BIN_W + 1);
    localparam logic [31:0] LIMIT    = 32'(10 ** DIGITS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [SW-1:0] NINES    = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [BIN_W-1:0]  bin_r, bin_s;
    logic [SW-1:0]     scratch_r, scratch_s, step_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic              ovf_lat_r, ovf_lat_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic [SW-1:0]     bcd_r, bcd_s;
    logic              ovf_r, ovf_s;
    logic [BIN_W-1:0]  mag_s;
    logic              ovf_in_s;
    logic              accept_s;
`ifdef SIGNED_IN_EN
    logic              neg_lat_r, neg_lat_s;
    logic              neg_r, neg_s;
`endif

    // Add 3 to every digit >= 5, then shift left by one pulling in the next binary bit.
    function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s, input logic msb);
        logic [SW-1:0] adj;
        adj = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = s[4*i +: 4];
            end
        end
        return {adj[SW-2:0], msb};
    endfunction

    // Input magnitude and overflow decision for the accepting edge
    always_comb begin
`ifdef SIGNED_IN_EN
        if (bus.bin_in[BIN_W-1]) begin
            mag_s = ~bus.bin_in + {{(BIN_W-1){1'b0}}, 1'b1};
        end else begin
            mag_s = bus.bin_in;
        end
`else
        mag_s = bus.bin_in;
`endif
        ovf_in_s = ({{(32-BIN_W){1'b0}}, mag_s} > LIMIT);
        step_s   = dabble_step(scratch_r, bin_r[BIN_W-1]);
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_s   = state_r;
        bin_s     = bin_r;
        scratch_s = scratch_r;
        cnt_s     = cnt_r;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        bcd_s     = bcd_r;
        ovf_s     = ovf_r;
        accept_s  = 1'b0;
`ifdef SIGNED_IN_EN
        neg_s     = neg_r;
`endif
        case (state_r)
            IDLE: begin
                if (bus.start) accept_s = 1'b1;
                else           state_s  = IDLE;
            end
            SHIFT: begin
                scratch_s = step_s;
                bin_s     = {bin_r[BIN_W-2:0], 1'b0};
                cnt_s     = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = DONE;
                    done_s  = 1'b1;
                    bcd_s   = ovf_lat_r ? NINES : step_s;
                    ovf_s   = ovf_lat_r;
`ifdef SIGNED_IN_EN
                    neg_s   = neg_lat_r;
`endif
                end else begin
                    busy_s  = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) accept_s = 1'b1;
                else           state_s  = IDLE;
            end
            default: state_s = IDLE;
        endcase

        if (accept_s) begin
            state_s   = SHIFT;
            bin_s     = mag_s;
            scratch_s = '0;
            cnt_s     = CNT_LOAD;
            busy_s    = 1'b1;
            ovf_lat_s = ovf_in_s;
`ifdef SIGNED_IN_EN
            neg_lat_s = bus.bin_in[BIN_W-1];
`endif
        end else begin
            ovf_lat_s = ovf_lat_r;
`ifdef SIGNED_IN_EN
            neg_lat_s = neg_lat_r;
`endif
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_s;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r     <= '0;
            scratch_r <= '0;
            cnt_r     <= '0;
            ovf_lat_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            bcd_r     <= '0;
            ovf_r     <= 1'b0;
`ifdef SIGNED_IN_EN
            neg_lat_r <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            bin_r     <= bin_s;
            scratch_r <= scratch_s;
            cnt_r     <= cnt_s;
            ovf_lat_r <= ovf_lat_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            bcd_r     <= bcd_s;
            ovf_r     <= ovf_s;
`ifdef SIGNED_IN_EN
            neg_lat_r <= neg_lat_s;
            neg_r     <= neg_s;
`endif
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.bcd_out  = bcd_r;
    assign bus.overflow = ovf_r;
`ifdef SIGNED_IN_EN
    assign bus.neg      = neg_r;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq; expectations are hand-computed BCD values.
module tb_bin_to_bcd_seq;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus_i ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion with exact-latency checks; bin_in is scrambled after the accepting edge.
    task automatic convert(input string tag, input logic [BIN_W-1:0] val,
                           input logic [31:0] exp_bcd, input logic [31:0] exp_ovf);
        @(negedge clk);
        bus_i.start  = 1'b1;
        bus_i.bin_in = val;
        @(posedge clk); #1;
        bus_i.start  = 1'b0;
        bus_i.bin_in = ~val;
        check({tag, "/busy_at_accept"}, 32'(bus_i.busy), 32'd1);
        for (int i = 1; i < BIN_W; i++) begin
            @(posedge clk); #1;
            check({tag, "/busy_mid"}, 32'(bus_i.busy), 32'd1);
            check({tag, "/done_mid"}, 32'(bus_i.done), 32'd0);
        end
        @(posedge clk); #1;
        check({tag, "/done"},     32'(bus_i.done),     32'd1);
        check({tag, "/busy_off"}, 32'(bus_i.busy),     32'd0);
        check({tag, "/bcd"},      32'(bus_i.bcd_out),  exp_bcd);
        check({tag, "/ovf"},      32'(bus_i.overflow), exp_ovf);
        @(posedge clk); #1;
        check({tag, "/done_pulse"}, 32'(bus_i.done),    32'd0);
        check({tag, "/bcd_hold"},   32'(bus_i.bcd_out), exp_bcd);
    endtask

    initial begin
        int seen;
        rst          = 1'b1;
        bus_i.start  = 1'b0;
        bus_i.bin_in = '0;
        #12;
        check("rst/busy", 32'(bus_i.busy),     32'd0);
        check("rst/done", 32'(bus_i.done),     32'd0);
        check("rst/bcd",  32'(bus_i.bcd_out),  32'd0);
        check("rst/ovf",  32'(bus_i.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        convert("zero", 14'd0,  32'h0000, 32'd0);
        convert("c42",  14'd42, 32'h0042, 32'd0);
`ifndef SIGNED_IN_EN
        convert("c9801",  14'd9801,  32'h9801, 32'd0);
        convert("c9999",  14'd9999,  32'h9999, 32'd0);
        convert("c10000", 14'd10000, 32'h9999, 32'd1);
        convert("c16383", 14'd16383, 32'h9999, 32'd1);
        convert("c42b",   14'd42,    32'h0042, 32'd0);
`endif

        // Back-to-back: start held, bin_in changes while busy.
        @(negedge clk);
        bus_i.start  = 1'b1;
        bus_i.bin_in = 14'd1234;
        @(posedge clk); #1;
        check("b2b/busy1", 32'(bus_i.busy), 32'd1);
        for (int i = 1; i < BIN_W; i++) begin
            @(posedge clk); #1;
            if (i == 5) bus_i.bin_in = 14'd77;
            check("b2b/done1_mid", 32'(bus_i.done), 32'd0);
        end
        @(posedge clk); #1;
        check("b2b/done1", 32'(bus_i.done),    32'd1);
        check("b2b/bcd1",  32'(bus_i.bcd_out), 32'h1234);
        @(posedge clk); #1;
        check("b2b/reaccept_busy", 32'(bus_i.busy), 32'd1);
        check("b2b/reaccept_done", 32'(bus_i.done), 32'd0);
        bus_i.start  = 1'b0;
        bus_i.bin_in = 14'd0;
        for (int i = 1; i < BIN_W; i++) begin
            @(posedge clk); #1;
            check("b2b/done2_mid", 32'(bus_i.done),    32'd0);
            check("b2b/bcd_hold",  32'(bus_i.bcd_out), 32'h1234);
        end
        @(posedge clk); #1;
        check("b2b/done2", 32'(bus_i.done),    32'd1);
        check("b2b/bcd2",  32'(bus_i.bcd_out), 32'h0077);
        @(posedge clk); #1;
        check("b2b/idle_busy", 32'(bus_i.busy), 32'd0);
        check("b2b/idle_done", 32'(bus_i.done), 32'd0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bus_i.start  = 1'b1;
        bus_i.bin_in = 14'd5555;
        @(posedge clk); #1;
        bus_i.start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst/busy", 32'(bus_i.busy),     32'd0);
        check("midrst/done", 32'(bus_i.done),     32'd0);
        check("midrst/bcd",  32'(bus_i.bcd_out),  32'd0);
        check("midrst/ovf",  32'(bus_i.overflow), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus_i.done === 1'b1) seen++;
        end
        check("midrst/no_done", 32'(seen), 32'd0);
        convert("c12", 14'd12, 32'h0012, 32'd0);

`ifdef SIGNED_IN_EN
        check("c12/neg", 32'(bus_i.neg), 32'd0);
        convert("m123", 14'h3F85, 32'h0123, 32'd0);
        check("m123/neg", 32'(bus_i.neg), 32'd1);
        convert("m8192", 14'h2000, 32'h8192, 32'd0);
        check("m8192/neg", 32'(bus_i.neg), 32'd1);
        convert("s0", 14'd0, 32'h0000, 32'd0);
        check("s0/neg", 32'(bus_i.neg), 32'd0);
        convert("p8191", 14'd8191, 32'h8191, 32'd0);
        check("p8191/neg", 32'(bus_i.neg), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
